// File: rtl/pc_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trace_monitor
//  Purpose  : Observes the retired-PC stream of the system under test,
//             buffers the PCs in a first-word-fall-through FIFO drained
//             over a valid/ready trace port, counts retirements and RUN
//             cycles, and ends the run on a halt (self-loop) or a watchdog
//             timeout.
//  Ports    : CLK             clock, all state changes on posedge
//             RESET           synchronous active-low reset
//             in_pc           retired PC
//             in_pc_enable    one retirement this cycle
//             in_trace_ready  consumer accepts the FIFO head
//             out_trace_valid FIFO non-empty
//             out_trace_pc    FIFO head PC (0 when empty)
//             out_retired     saturating count of retirements in RUN
//             out_cycles      saturating count of cycles in RUN
//             out_overflow    sticky: a retirement was dropped on full FIFO
//             out_halted      terminal state HALTED
//             out_timeout     terminal state TIMEOUT
//             out_done        terminal state reached and FIFO drained
//  Revision : 1.0  initial release
// ============================================================================
module pc_trace_monitor #(
    parameter int DEPTH          = 16,
    parameter int HALT_REPEAT    = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      in_pc,
    input  logic             in_pc_enable,
    input  logic             in_trace_ready,
    output logic             out_trace_valid,
    output logic [31:0]      out_trace_pc,
    output logic [CNT_W-1:0] out_retired,
    output logic [CNT_W-1:0] out_cycles,
    output logic             out_overflow,
    output logic             out_halted,
    output logic             out_timeout,
    output logic             out_done
);

    localparam int               c_addr_w    = $clog2(DEPTH);
    localparam int               c_rep_w     = $clog2(HALT_REPEAT + 1);
    localparam logic [c_addr_w:0] c_depth    = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_rep_w-1:0] c_halt_rep = c_rep_w'(HALT_REPEAT);
    // Compared in 64 bits so a timeout beyond the counter range never fires
    // through truncation.
    localparam logic [63:0]      c_timeout   = 64'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [31:0]          r_mem [DEPTH];
    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [c_addr_w:0]    r_wr_ptr;
    logic [c_addr_w:0]    r_rd_ptr;
    logic [c_addr_w:0]    w_count;
    logic                 w_empty;
    logic                 w_full;

    logic [CNT_W-1:0]     r_retired;
    logic [CNT_W-1:0]     r_cycles;
    logic [CNT_W-1:0]     w_cycles_next;
    logic                 r_overflow;
    logic [31:0]          r_last_pc;
    logic                 r_last_valid;
    logic [c_rep_w-1:0]   r_repeat;
    logic [c_rep_w-1:0]   w_repeat_next;

    logic                 w_running;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_halt;
    logic                 w_timeout;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (w_count == c_depth);

    assign w_running = (r_state == ST_RUN);
    assign w_capture = w_running && in_pc_enable;
    // An empty FIFO has no valid head, so a same-cycle push is never popped.
    assign w_pop     = !w_empty && in_trace_ready;
    // A pop frees the slot the push needs when the FIFO is full.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    assign w_cycles_next = (r_cycles == c_cnt_max) ? r_cycles : r_cycles + 1'b1;
    assign w_repeat_next = (r_last_valid && (in_pc == r_last_pc))
                         ? r_repeat + 1'b1 : c_rep_w'(1);
    assign w_halt    = w_capture && (w_repeat_next == c_halt_rep);
    assign w_timeout = w_running && (64'(w_cycles_next) == c_timeout);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                // Halt takes priority over a coincident timeout.
                if (w_halt)
                    w_state_next = ST_HALTED;
                else if (w_timeout)
                    w_state_next = ST_TIMEOUT;
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state      <= ST_RUN;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_retired    <= '0;
            r_cycles     <= '0;
            r_overflow   <= 1'b0;
            r_last_pc    <= '0;
            r_last_valid <= 1'b0;
            r_repeat     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_running)
                r_cycles <= w_cycles_next;
            if (w_capture) begin
                if (r_retired != c_cnt_max)
                    r_retired <= r_retired + 1'b1;
                r_last_pc    <= in_pc;
                r_last_valid <= 1'b1;
                r_repeat     <= w_repeat_next;
            end
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= in_pc;
    end

    assign out_trace_valid = !w_empty;
    assign out_trace_pc    = w_empty ? 32'h0 : r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign out_retired     = r_retired;
    assign out_cycles      = r_cycles;
    assign out_overflow    = r_overflow;
    assign out_halted      = (r_state == ST_HALTED);
    assign out_timeout     = (r_state == ST_TIMEOUT);
    assign out_done        = !w_running && w_empty;

endmodule
`default_nettype wire
